// File: rtl/avalon_stream_arbiter_if.sv
// Avalon-ST handshake bundle between NUM_INPUTS sources, the arbiter and its single sink.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface avalon_stream_arbiter_if #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_WIDTH = $clog2(NUM_INPUTS)
);
    logic [NUM_INPUTS-1:0]            asi_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] asi_data;
    logic [NUM_INPUTS-1:0]            asi_ready;
    logic                             aso_valid;
    logic [DATA_WIDTH-1:0]            aso_data;
    logic [CHANNEL_WIDTH-1:0]         aso_channel;
    logic                             aso_ready;

    modport slave (
        input  asi_valid, asi_data, aso_ready,
        output asi_ready, aso_valid, aso_data, aso_channel
    );

    modport master (
        output asi_valid, asi_data, aso_ready,
        input  asi_ready, aso_valid, aso_data, aso_channel
    );
endinterface

// File: rtl/avalon_stream_arbiter.sv
// Round-robin Avalon-ST arbiter: bursts of up to MAX_BURST beats, one ARB bubble per grant, 1-cycle registered output.
// Backpressure: the granted source sees ready only while the output register is empty or being drained.
module avalon_stream_arbiter #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_BURST     = 4,
    parameter int CHANNEL_WIDTH = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_stream_arbiter_if.slave bus
);
    localparam int SW = CHANNEL_WIDTH + 1;

    typedef enum logic {ARB, GRANT} state_t;

    typedef struct packed {
        logic [CHANNEL_WIDTH-1:0] channel;
        logic [DATA_WIDTH-1:0]    data;
    } beat_t;

    state_t                   state;
    logic [CHANNEL_WIDTH-1:0] grant;
    logic [CHANNEL_WIDTH-1:0] rr_ptr;
    logic [7:0]               beats;
    logic                     out_vld;
    beat_t                    out_beat;

    logic [CHANNEL_WIDTH-1:0] pick;
    logic                     pick_vld;
    logic [CHANNEL_WIDTH-1:0] grant_next;
    logic [DATA_WIDTH-1:0]    grant_data;
    logic [NUM_INPUTS-1:0]    rdy;
    logic                     out_free;
    logic                     xfer;
    logic                     last_beat;
    logic                     src_drop;

    assign out_free = !out_vld || bus.aso_ready;

    // Search from rr_ptr upward with wrap; the sum stays below 2*NUM_INPUTS.
    always_comb begin : rr_search
        logic [SW-1:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int off = 0; off < NUM_INPUTS; off++) begin
            idx = {1'b0, rr_ptr} + SW'(off);
            if (idx >= SW'(NUM_INPUTS)) begin
                idx = idx - SW'(NUM_INPUTS);
            end
            if (!pick_vld && bus.asi_valid[idx[CHANNEL_WIDTH-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[CHANNEL_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        rdy        = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant == CHANNEL_WIDTH'(i)) begin
                grant_data = bus.asi_data[i*DATA_WIDTH +: DATA_WIDTH];
                rdy[i]     = (state == GRANT) && out_free;
            end
        end
    end

    assign xfer       = (state == GRANT) && bus.asi_valid[grant] && out_free;
    assign src_drop   = (state == GRANT) && out_free && !bus.asi_valid[grant];
    assign last_beat  = (beats == 8'(MAX_BURST - 1));
    assign grant_next = (grant == CHANNEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB;
            grant    <= '0;
            rr_ptr   <= '0;
            beats    <= '0;
            out_vld  <= 1'b0;
            out_beat <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (pick_vld) begin
                        grant <= pick;
                        beats <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        beats <= beats + 8'd1;
                        if (last_beat) begin
                            state  <= ARB;
                            rr_ptr <= grant_next;
                        end
                    end else if (src_drop) begin
                        state  <= ARB;
                        rr_ptr <= grant_next;
                    end
                end
                default: state <= ARB;
            endcase

            // A full, unconsumed output register holds its beat untouched.
            if (out_free) begin
                out_vld <= xfer;
                if (xfer) begin
                    out_beat.channel <= grant;
                    out_beat.data    <= grant_data;
                end
            end
        end
    end

    assign bus.asi_ready   = rdy;
    assign bus.aso_valid   = out_vld;
    assign bus.aso_data    = out_beat.data;
    assign bus.aso_channel = out_beat.channel;
endmodule

// File: tb/tb_avalon_stream_arbiter.sv
// Scoreboard bench: per-channel FIFOs of accepted source beats, plus an ordered expectation queue for directed cases.
module tb_avalon_stream_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 2;

    logic clk;
    logic reset;

    avalon_stream_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) bus();

    avalon_stream_arbiter #(
        .NUM_INPUTS(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .CHANNEL_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int chan;
        int data;
        int gap;
    } exp_t;

    exp_t           exp_q[$];
    logic [DW-1:0]  src_q[N][$];
    logic [DW-1:0]  chan_q[N][$];
    int             total;
    int             bad;
    int             rdy_mode;
    bit             vld_rand;
    bit             directed;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0) || (bus.aso_valid === 1'b1);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0 || chan_q[i].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic clear_all();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            chan_q[i].delete();
        end
    endtask

    task automatic load(input int src, input int data, input int gap, input bit with_exp);
        exp_t e;
        src_q[src].push_back(DW'(data));
        if (with_exp) begin
            e.chan = src;
            e.data = data;
            e.gap  = gap;
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; leaves reset asserted so the caller can load the next case.
    task automatic start_case();
        reset = 1'b0;
        clear_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (n < limit && busy()) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, int'(n < limit), 1);
    endtask

    // Source and sink driver: inputs change at negedge, handshakes are recorded 1 time unit later.
    initial begin : driver
        bus.asi_valid = '0;
        bus.asi_data  = '0;
        bus.aso_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.aso_ready = 1'b1;
                1:       bus.aso_ready = 1'($urandom_range(0, 1));
                default: bus.aso_ready = 1'b0;
            endcase
            for (int i = 0; i < N; i++) begin
                bit v;
                v = reset && (src_q[i].size() != 0) && (!vld_rand || $urandom_range(0, 3) != 0);
                bus.asi_valid[i] = v;
                bus.asi_data[i*DW +: DW] = v ? src_q[i][0] : '0;
            end
            #1;
            if (reset) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.asi_valid[i] && bus.asi_ready[i]) begin
                        chan_q[i].push_back(src_q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin : monitor
        int            cyc;
        int            last_acc;
        bit            pv;
        logic [DW-1:0] pd;
        logic [CW-1:0] pc;
        cyc      = 0;
        last_acc = 0;
        pv       = 1'b0;
        pd       = '0;
        pc       = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!reset) begin
                pv = 1'b0;
                continue;
            end
            if (pv) begin
                check("hold_valid", int'(bus.aso_valid), 1);
                check("hold_data", int'(bus.aso_data), int'(pd));
                check("hold_chan", int'(bus.aso_channel), int'(pc));
            end
            if (bus.aso_valid && !bus.aso_ready) begin
                check("stall_asi_ready", int'(bus.asi_ready), 0);
            end
            pv = bus.aso_valid && !bus.aso_ready;
            pd = bus.aso_data;
            pc = bus.aso_channel;
            if (bus.aso_valid && bus.aso_ready) begin
                int c;
                c = int'(bus.aso_channel);
                check("beat_has_source", int'(chan_q[c].size() != 0), 1);
                if (chan_q[c].size() != 0) begin
                    check("chan_data", int'(bus.aso_data), int'(chan_q[c].pop_front()));
                end
                if (directed) begin
                    check("exp_available", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("order_chan", c, e.chan);
                        check("order_data", int'(bus.aso_data), e.data);
                        if (e.gap != 0) check("beat_gap", cyc - last_acc, e.gap);
                    end
                end
                last_acc = cyc;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        total    = 0;
        bad      = 0;
        rdy_mode = 0;
        vld_rand = 1'b0;
        directed = 1'b0;
        reset    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aso_valid", int'(bus.aso_valid), 0);
        check("rst_aso_data", int'(bus.aso_data), 0);
        check("rst_aso_channel", int'(bus.aso_channel), 0);
        check("rst_asi_ready", int'(bus.asi_ready), 0);

        // Burst limit: one source, 8 beats, bubble after each 4.
        start_case();
        directed = 1'b1;
        for (int k = 0; k < 8; k++) begin
            load(1, 'h10 + k, (k == 0) ? 0 : ((k % MB == 0) ? 2 : 1), 1'b1);
        end
        reset = 1'b1;
        drain("burst", 200);

        // Round robin: all sources continuously valid.
        start_case();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 8; k++) src_q[i].push_back(DW'((i << 4) | k));
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int b = 0; b < MB; b++) begin
                    exp_t e;
                    e.chan = i;
                    e.data = (i << 4) | (r * MB + b);
                    e.gap  = (r == 0 && i == 0 && b == 0) ? 0 : ((b == 0) ? 2 : 1);
                    exp_q.push_back(e);
                end
            end
        end
        reset = 1'b1;
        drain("round_robin", 300);

        // Early release: source 2 runs dry after 2 beats, source 3 follows after the ARB cycle.
        start_case();
        load(2, 'h20, 0, 1'b1);
        load(2, 'h21, 1, 1'b1);
        load(3, 'h30, 3, 1'b1);
        load(3, 'h31, 1, 1'b1);
        load(3, 'h32, 1, 1'b1);
        reset = 1'b1;
        drain("early_release", 200);

        // Downstream stalled for 12 cycles: only the first beat is taken.
        start_case();
        rdy_mode = 2;
        for (int k = 0; k < 6; k++) load(0, 'h50 + k, 0, 1'b1);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("stall_asi_ready0", int'(bus.asi_ready), 0);
        check("stall_aso_valid", int'(bus.aso_valid), 1);
        check("stall_aso_data", int'(bus.aso_data), 'h50);
        check("stall_aso_chan", int'(bus.aso_channel), 0);
        check("stall_src_left", src_q[0].size(), 5);
        rdy_mode = 0;
        drain("stall", 200);

        // Reset mid-transfer, then lowest-index valid source wins first.
        start_case();
        directed = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            load(0, 'hA0 + k, 0, 1'b0);
            load(2, 'hC0 + k, 0, 1'b0);
        end
        reset = 1'b1;
        begin
            int n;
            n = 0;
            while (n < 20 && !(bus.aso_valid && bus.aso_data != 0)) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("midrst_inflight", int'(n < 20), 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_aso_valid", int'(bus.aso_valid), 0);
        check("midrst_aso_data", int'(bus.aso_data), 0);
        check("midrst_aso_chan", int'(bus.aso_channel), 0);
        check("midrst_asi_ready", int'(bus.asi_ready), 0);
        clear_all();
        @(posedge clk);
        #1;
        directed = 1'b1;
        load(1, 'h11, 0, 1'b1);
        load(1, 'h12, 1, 1'b1);
        load(3, 'h31, 3, 1'b1);
        load(3, 'h32, 1, 1'b1);
        reset = 1'b1;
        drain("after_reset", 200);

        // Random valids and backpressure.
        start_case();
        directed = 1'b0;
        vld_rand = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 150; k++) src_q[i].push_back(DW'($urandom));
        end
        reset = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        vld_rand = 1'b0;
        rdy_mode = 0;
        drain("random", 3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
